// File: rtl/double_buffer_reader_if.sv
// Bundle of buffer-side and stream-side signals for double_buffer_reader.
// The slave modport is the reader's view; master is the producer/sink side.
interface double_buffer_reader_if #(
    parameter int DATA_WIDTH    = 4,
    parameter int ADDRESS_WIDTH = 2
);
    logic                     newData;
    logic [ADDRESS_WIDTH-1:0] dataLength;
    logic [ADDRESS_WIDTH-1:0] readPointer;
    logic [DATA_WIDTH-1:0]    dataIn;
    logic [DATA_WIDTH-1:0]    outData;
    logic                     outValid;
    logic                     outReady;
    logic                     outLast;
    logic                     busy;
    logic                     frameDone;
    logic                     overrun;

    modport slave (
        input  newData,
        input  dataLength,
        input  dataIn,
        input  outReady,
        output readPointer,
        output outData,
        output outValid,
        output outLast,
        output busy,
        output frameDone,
        output overrun
    );

    modport master (
        output newData,
        output dataLength,
        output dataIn,
        output outReady,
        input  readPointer,
        input  outData,
        input  outValid,
        input  outLast,
        input  busy,
        input  frameDone,
        input  overrun
    );
endinterface

// File: rtl/double_buffer_reader.sv
// Streams one frame out of the readable half of a double buffer per newData rising edge.
// First beat 2 clocks after the start edge, at most one word per 3 clocks; beats hold while outReady=0.
module double_buffer_reader #(
    parameter int DATA_WIDTH    = 4,
    parameter int ADDRESS_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    double_buffer_reader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LOAD,
        SEND,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] read_pointer_q, read_pointer_d;
    logic [ADDRESS_WIDTH-1:0] length_q, length_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic                     busy_q, busy_d;
    logic                     frame_done_q, frame_done_d;
    logic                     overrun_q, overrun_d;
    logic                     pending_q, pending_d;
    logic                     new_data_prev_q, new_data_prev_d;

    logic                     new_data_rise;
    logic [ADDRESS_WIDTH-1:0] last_index;

    assign new_data_rise = bus.newData & ~new_data_prev_q;
    assign last_index    = length_q - 1'b1;

    always_comb begin
        state_d         = state_q;
        read_pointer_d  = read_pointer_q;
        length_d        = length_q;
        out_data_d      = out_data_q;
        out_valid_d     = out_valid_q;
        out_last_d      = out_last_q;
        overrun_d       = overrun_q;
        pending_d       = pending_q;
        new_data_prev_d = bus.newData;

        case (state_q)
            IDLE: begin
                if (new_data_rise) begin
                    length_d       = bus.dataLength;
                    read_pointer_d = '0;
                    state_d        = (bus.dataLength == '0) ? DONE : ADDR;
                end
            end
            ADDR: begin
                state_d = LOAD;
            end
            LOAD: begin
                out_data_d  = bus.dataIn;
                out_valid_d = 1'b1;
                out_last_d  = (read_pointer_q == last_index);
                state_d     = SEND;
            end
            SEND: begin
                if (bus.outReady) begin
                    out_valid_d    = 1'b0;
                    out_last_d     = 1'b0;
                    read_pointer_d = read_pointer_q + 1'b1;
                    state_d        = out_last_q ? DONE : ADDR;
                end
            end
            DONE: begin
                // An edge arriving in DONE itself is treated as pending, so it is not lost.
                if (pending_q || new_data_rise) begin
                    length_d       = bus.dataLength;
                    read_pointer_d = '0;
                    state_d        = (bus.dataLength == '0) ? DONE : ADDR;
                    pending_d      = pending_q && new_data_rise;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Edges during an active frame queue at most one follow-up frame.
        if (new_data_rise && (state_q == ADDR || state_q == LOAD || state_q == SEND)) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            read_pointer_q  <= '0;
            length_q        <= '0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            overrun_q       <= 1'b0;
            pending_q       <= 1'b0;
            // Held high so a newData level already asserted at release is not an edge.
            new_data_prev_q <= 1'b1;
        end else begin
            state_q         <= state_d;
            read_pointer_q  <= read_pointer_d;
            length_q        <= length_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
            out_last_q      <= out_last_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
            overrun_q       <= overrun_d;
            pending_q       <= pending_d;
            new_data_prev_q <= new_data_prev_d;
        end
    end

    assign bus.readPointer = read_pointer_q;
    assign bus.outData     = out_data_q;
    assign bus.outValid    = out_valid_q;
    assign bus.outLast     = out_last_q;
    assign bus.busy        = busy_q;
    assign bus.frameDone   = frame_done_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_double_buffer_reader.sv
// Directed bench for double_buffer_reader: a per-cycle vector table for reset and a basic
// frame, then hand sequences for backpressure, empty frame, pending/overrun and abort.
module tb_double_buffer_reader;

    logic clock;
    logic reset;
    logic [3:0] mem [4];

    int errors = 0;
    int checks = 0;

    double_buffer_reader_if #(.DATA_WIDTH(4), .ADDRESS_WIDTH(2)) bus ();

    double_buffer_reader #(.DATA_WIDTH(4), .ADDRESS_WIDTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Buffer model: read data appears one clock after readPointer is sampled.
    always @(posedge clock) bus.dataIn <= mem[bus.readPointer];

    typedef struct {
        logic       rst;
        logic       nd;
        logic [1:0] len;
        logic       rdy;
        logic       vld;
        logic [3:0] dat;
        logic       last;
        logic [1:0] rp;
        logic       busy;
        logic       done;
        logic       ovr;
    } vec_t;

    function automatic vec_t v(input logic rst, input logic nd, input logic [1:0] len,
                               input logic rdy, input logic vld, input logic [3:0] dat,
                               input logic last, input logic [1:0] rp, input logic busy,
                               input logic done, input logic ovr);
        vec_t r;
        r.rst = rst; r.nd = nd; r.len = len; r.rdy = rdy;
        r.vld = vld; r.dat = dat; r.last = last; r.rp = rp;
        r.busy = busy; r.done = done; r.ovr = ovr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic vld, input logic [3:0] dat,
                             input logic last, input logic [1:0] rp, input logic busy,
                             input logic done, input logic ovr);
        chk({tag, ".outValid"},    {31'd0, bus.outValid},    {31'd0, vld});
        chk({tag, ".outData"},     {28'd0, bus.outData},     {28'd0, dat});
        chk({tag, ".outLast"},     {31'd0, bus.outLast},     {31'd0, last});
        chk({tag, ".readPointer"}, {30'd0, bus.readPointer}, {30'd0, rp});
        chk({tag, ".busy"},        {31'd0, bus.busy},        {31'd0, busy});
        chk({tag, ".frameDone"},   {31'd0, bus.frameDone},   {31'd0, done});
        chk({tag, ".overrun"},     {31'd0, bus.overrun},     {31'd0, ovr});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_456();
        mem[0] = 4'd4; mem[1] = 4'd5; mem[2] = 4'd6; mem[3] = 4'd0;
    endtask

    vec_t vecs [21];

    initial begin
        reset          = 1'b1;
        bus.newData    = 1'b1;
        bus.dataLength = 2'd0;
        bus.outReady   = 1'b0;
        load_456();

        // rst nd len rdy | vld dat last rp busy done ovr
        vecs[0]  = v(1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = v(1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = v(1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = v(0, 1, 3, 1,  0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = v(0, 1, 3, 1,  0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = v(0, 1, 3, 1,  0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = v(0, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0);
        vecs[7]  = v(0, 1, 3, 1,  0, 0, 0, 0, 1, 0, 0);
        vecs[8]  = v(0, 1, 3, 1,  0, 0, 0, 0, 1, 0, 0);
        vecs[9]  = v(0, 1, 3, 1,  1, 4, 0, 0, 1, 0, 0);
        vecs[10] = v(0, 1, 3, 1,  0, 4, 0, 1, 1, 0, 0);
        vecs[11] = v(0, 1, 3, 1,  0, 4, 0, 1, 1, 0, 0);
        vecs[12] = v(0, 1, 3, 1,  1, 5, 0, 1, 1, 0, 0);
        vecs[13] = v(0, 1, 3, 1,  0, 5, 0, 2, 1, 0, 0);
        vecs[14] = v(0, 1, 3, 1,  0, 5, 0, 2, 1, 0, 0);
        vecs[15] = v(0, 1, 3, 1,  1, 6, 1, 2, 1, 0, 0);
        vecs[16] = v(0, 1, 3, 1,  0, 6, 0, 3, 1, 1, 0);
        vecs[17] = v(0, 1, 3, 1,  0, 6, 0, 3, 0, 0, 0);
        vecs[18] = v(0, 1, 3, 1,  0, 6, 0, 3, 0, 0, 0);
        vecs[19] = v(0, 0, 3, 1,  0, 6, 0, 3, 0, 0, 0);
        vecs[20] = v(0, 0, 3, 1,  0, 6, 0, 3, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            reset          = vecs[i].rst;
            bus.newData    = vecs[i].nd;
            bus.dataLength = vecs[i].len;
            bus.outReady   = vecs[i].rdy;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].vld, vecs[i].dat, vecs[i].last,
                      vecs[i].rp, vecs[i].busy, vecs[i].done, vecs[i].ovr);
        end

        // Backpressure: single word 8, sink stalls for 5 clocks.
        mem[0] = 4'd8;
        bus.newData = 1'b0; bus.dataLength = 2'd1; bus.outReady = 1'b0;
        tick();
        bus.newData = 1'b1;
        tick(); check_all("bp_addr", 0, 6, 0, 0, 1, 0, 0);
        tick(); check_all("bp_load", 0, 6, 0, 0, 1, 0, 0);
        tick(); check_all("bp_send", 1, 8, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(); check_all($sformatf("bp_hold%0d", i), 1, 8, 1, 0, 1, 0, 0);
        end
        bus.outReady = 1'b1;
        tick(); check_all("bp_accept", 0, 8, 0, 1, 1, 1, 0);
        tick(); check_all("bp_idle", 0, 8, 0, 1, 0, 0, 0);

        // Empty frame.
        bus.newData = 1'b0; bus.dataLength = 2'd0;
        tick();
        bus.newData = 1'b1;
        tick(); check_all("empty_done", 0, 8, 0, 0, 1, 1, 0);
        tick(); check_all("empty_idle", 0, 8, 0, 0, 0, 0, 0);
        tick(); check_all("empty_after", 0, 8, 0, 0, 0, 0, 0);

        // Pending and overrun: edges at cycle 2 (pending) and 4 (overrun); length changes to 2
        // at cycle 5, so the running frame keeps 3 and the pending one takes 2.
        load_456();
        bus.newData = 1'b0; bus.dataLength = 2'd3; bus.outReady = 1'b1;
        tick();
        for (int e = 0; e < 18; e++) begin
            bus.newData    = (e == 1 || e == 3) ? 1'b0 : 1'b1;
            bus.dataLength = (e >= 5) ? 2'd2 : 2'd3;
            tick();
            case (e)
                2:  check_all("pd_beat0", 1, 4, 0, 0, 1, 0, 0);
                3:  check_all("pd_pending", 0, 4, 0, 1, 1, 0, 0);
                4:  check_all("pd_overrun", 0, 4, 0, 1, 1, 0, 1);
                8:  check_all("pd_beat2", 1, 6, 1, 2, 1, 0, 1);
                9:  check_all("pd_done1", 0, 6, 0, 3, 1, 1, 1);
                10: check_all("pd_restart", 0, 6, 0, 0, 1, 0, 1);
                12: check_all("pd_f2_beat0", 1, 4, 0, 0, 1, 0, 1);
                15: check_all("pd_f2_beat1", 1, 5, 1, 1, 1, 0, 1);
                16: check_all("pd_done2", 0, 5, 0, 2, 1, 1, 1);
                17: check_all("pd_idle", 0, 5, 0, 2, 0, 0, 1);
                default: ;
            endcase
        end
        tick(); tick();
        check_all("pd_sticky", 0, 5, 0, 2, 0, 0, 1);
        reset = 1'b1;
        tick(); check_all("pd_reset", 0, 0, 0, 0, 0, 0, 0);

        // Abort after the first accepted beat of a 3-word frame.
        reset = 1'b0; bus.newData = 1'b0; bus.dataLength = 2'd3; bus.outReady = 1'b1;
        tick();
        bus.newData = 1'b1;
        tick(); tick();
        tick(); check_all("ab_beat0", 1, 4, 0, 0, 1, 0, 0);
        tick(); check_all("ab_accept", 0, 4, 0, 1, 1, 0, 0);
        reset = 1'b1;
        tick(); check_all("ab_reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(); check_all($sformatf("ab_quiet%0d", i), 0, 0, 0, 0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/double_buffer_reader.md
DOUBLE_BUFFER_READER -- requirements
Module: double_buffer_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, the word width, equal to the buffer word width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 2, the buffer address width.
REQ-003 The block SHALL have port clock  in  1  the single clock, rising-edge active.
REQ-004 The block SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port newData  in  1  buffer-swap indication from the double buffer.
REQ-006 The block SHALL have port dataLength  in  ADDRESS_WIDTH  the number of valid words in the readable buffer.
REQ-007 The block SHALL have port readPointer  out  ADDRESS_WIDTH  the read address presented to the buffer.
REQ-008 The block SHALL have port dataIn  in  DATA_WIDTH  the buffer read data, valid one clock after readPointer is sampled.
REQ-009 The block SHALL have port outData  out  DATA_WIDTH  the stream data.
REQ-010 The block SHALL have port outValid  out  1  the stream valid.
REQ-011 The block SHALL have port outReady  in  1  the stream ready from the downstream sink.
REQ-012 The block SHALL have port outLast  out  1  which marks the final word of a frame.
REQ-013 The block SHALL have ports busy  out  1  (frame in progress), frameDone  out  1  (one-cycle pulse) and overrun  out  1  (sticky error).

Function
REQ-014 The block SHALL start a frame only on a 0->1 transition of newData, sampled on clock; the previous-sample register SHALL reset to 1, so a newData level that is already high at reset release does not start a frame.
REQ-015 At frame start the block SHALL latch dataLength into an internal length register; later dataLength changes SHALL NOT affect the running frame.
REQ-016 The block SHALL implement a state machine with states IDLE, ADDR, LOAD, SEND and DONE.
REQ-017 On a frame start with latched length > 0, the block SHALL set readPointer to 0 and go from IDLE to ADDR.
REQ-018 On a frame start with latched length == 0, the block SHALL go from IDLE to DONE, with no outValid and readPointer set to 0.
REQ-019 ADDR SHALL last one cycle and then go to LOAD, giving the buffer one cycle to sample readPointer.
REQ-020 On leaving LOAD the block SHALL register outData<=dataIn and outValid<=1, and SHALL set outLast<=1 when readPointer == length-1; the next state SHALL be SEND.
REQ-021 In SEND, outData, outValid, outLast and readPointer SHALL hold stable while outReady=0.
REQ-022 In SEND with outReady=1, the beat SHALL be accepted: outValid<=0, outLast<=0 and readPointer<=readPointer+1; if the accepted beat was the last, the next state SHALL be DONE, otherwise ADDR.
REQ-023 After a frame, readPointer SHALL rest at the latched length; the producer uses readPointer == dataLength as its read-complete condition.
REQ-024 DONE SHALL last one cycle, assert frameDone=1 for that cycle only, and go to IDLE, or directly to ADDR if a frame is pending.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 A newData rising edge while busy SHALL set a pending flag, and the pending frame SHALL start from DONE using the dataLength value sampled when it starts.
REQ-027 A newData rising edge while the pending flag is already set SHALL set overrun=1, the extra edge SHALL be dropped, and overrun SHALL clear only on reset.
REQ-028 First outValid SHALL occur 2 clocks after the edge that detects the frame start, and throughput SHALL be at most one word per 3 clocks.
REQ-029 readPointer arithmetic SHALL be ADDRESS_WIDTH bits with no wrap, because the latched length is at most 2^ADDRESS_WIDTH-1.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL go to IDLE with readPointer=0, outData=0, outValid=0, outLast=0, busy=0, frameDone=0, overrun=0, pending=0, length=0 and the previous-newData register=1.
REQ-031 A reset in the middle of a frame SHALL abort the frame immediately, discarding the pending frame and any unsent word.

Verification
REQ-032 Reset: assert reset for 3 clocks with newData=1 -> all outputs 0; release with newData held at 1 -> no frame starts.
REQ-033 Basic frame: buffer model holds 4,5,6, dataLength=3, outReady=1, newData 0->1 -> beats 4,5,6 with outLast only on 6, then frameDone pulse, readPointer=3.
REQ-034 Backpressure: word 8 at address 0, outReady=0 for 5 clocks -> outData=8 and outValid=1 stable and readPointer=0 throughout; outReady=1 -> accepted and readPointer=1.
REQ-035 Empty frame: dataLength=0, newData edge -> no outValid, frameDone high for exactly one cycle, readPointer=0.
REQ-036 Pending and overrun: a second newData edge during a 3-word frame -> the second frame starts straight after DONE with no IDLE cycle; a third edge while pending -> overrun=1 held until reset.
REQ-037 Abort: reset after the first beat of a 3-word frame is accepted -> all outputs return to reset values and no further beats are sent.
